// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, bus register
// offsets and STATUS register bit positions, plus a helper that packs STATUS.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  // Word offsets decoded from bus_addr[0].
  localparam logic RegData   = 1'b0;
  localparam logic RegStatus = 1'b1;

  // STATUS register layout.
  localparam int unsigned StatFullBit  = 0;
  localparam int unsigned StatEmptyBit = 1;
  localparam int unsigned StatBusyBit  = 2;
  localparam int unsigned StatOvfBit   = 3;
  localparam int unsigned StatCountLsb = 8;

  function automatic logic [31:0] status_word(logic [7:0] count, logic ovf, logic busy,
                                              logic empty, logic full);
    logic [31:0] w;
    w                       = '0;
    w[StatCountLsb +: 8]    = count;
    w[StatOvfBit]           = ovf;
    w[StatBusyBit]          = busy;
    w[StatEmptyBit]         = empty;
    w[StatFullBit]          = full;
    return w;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Word-addressed register bus used to reach the UART transmitter.
//   sel        : chip select, qualifies every access
//   bus_addr   : word address (only bit 0 is decoded by the UART)
//   bus_data_w : write data
//   bus_mask_w : byte write enables, all-zero means read
//   bus_data_r : registered read data (returned the cycle after a read)
interface uart_if;
  logic        sel;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_r;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;

  modport master (
    output sel, bus_addr, bus_data_w, bus_mask_w,
    input  bus_data_r
  );

  modport slave (
    input  sel, bus_addr, bus_data_w, bus_mask_w,
    output bus_data_r
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, 8-bit entries.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (empties the FIFO)
//   push_i  : write data_i; ignored when full at the start of the cycle
//   data_i  : write data
//   pop_i   : discard head entry; ignored when empty
//   data_o  : head entry (valid when !empty_o)
//   full_o  : count == DEPTH
//   empty_o : count == 0
//   count_o : number of stored entries
module sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a push into a full FIFO is dropped
  // even if a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are exactly PtrW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1, LSB first, idle high) with a byte FIFO behind a simple
// register bus.
//   clock : single clock, rising edge
//   reset : synchronous active-high reset; aborts any frame and empties the FIFO
//   bus   : register bus (slave side); DATA (offset 0) write pushes a byte,
//           STATUS (offset 1) read returns {count, overflow, busy, empty, full},
//           STATUS write with data bit 3 clears the sticky overflow flag
//   tx    : serial line
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DIV   = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic  clock,
  input  logic  reset,
  uart_if.slave bus,
  output logic  tx
);
  localparam int unsigned BaudW = $clog2(DIV);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam logic [BaudW-1:0] BaudReload = BaudW'(DIV - 1);

  uart_state_e      state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      rdata_q, rdata_d;

  logic            bus_rd, bus_wr, ovf_clr, busy;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_data;
  logic [CntW-1:0] fifo_count;
  logic            unused_bus;

  assign unused_bus = ^{bus.bus_addr[29:1], bus.bus_data_w[31:8]};

  // Bus decode; accesses during reset are ignored. Writes only care about lane 0.
  assign bus_rd    = bus.sel && (bus.bus_mask_w == 4'b0000) && !reset;
  assign bus_wr    = bus.sel && bus.bus_mask_w[0] && !reset;
  assign fifo_push = bus_wr && (bus.bus_addr[0] == RegData);
  assign ovf_clr   = bus_wr && (bus.bus_addr[0] == RegStatus) && bus.bus_data_w[3];
  assign busy      = (state_q != StIdle);

  assign bus.bus_data_r = rdata_q;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (bus.bus_data_w[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Overflow flag and read data; STATUS reflects values before this cycle's update.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_push && fifo_full) ovf_d = 1'b1;  // a new drop beats a clear
    else if (ovf_clr)           ovf_d = 1'b0;

    rdata_d = '0;
    if (bus_rd && (bus.bus_addr[0] == RegStatus)) begin
      rdata_d = status_word(8'(fifo_count), ovf_q, busy, fifo_empty, fifo_full);
    end
  end

  // Frame sequencer: each of START, 8 data bits and STOP lasts DIV cycles.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx       = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          baud_d   = BaudReload;
          state_d  = StStart;
        end
      end
      StStart: begin
        tx = 1'b0;
        if (baud_q == '0) begin
          baud_d  = BaudReload;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        tx = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BaudReload;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_q == '0) state_d = StIdle;
        else              baud_d  = baud_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DIV, default 16, clock cycles per UART bit (>=2).
REQ-002 SHALL have parameter DEPTH, default 16, transmit FIFO entries (power of two, >=2).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sel  input  1  chip select from the bus address decoder; qualifies every bus access.
REQ-006 SHALL have port bus_addr  input  30  word address; only bit 0 decoded (0 = DATA, 1 = STATUS).
REQ-007 SHALL have port bus_data_r  output  32  registered read data.
REQ-008 SHALL have port bus_data_w  input  32  write data.
REQ-009 SHALL have port bus_mask_w  input  4  byte write enables; all-zero means read.
REQ-010 SHALL have port tx  output  1  UART serial line, 8N1, LSB first, idle high.

Function
REQ-011 SHALL push bus_data_w[7:0] into the FIFO when sel, bus_addr[0]=0 and bus_mask_w[0]=1; other lanes ignored.
REQ-012 SHALL drop a push when the FIFO is full at the start of that cycle, even if a pop occurs in the same cycle, and set sticky overflow.
REQ-013 SHALL clear overflow on a STATUS write with bus_mask_w[0]=1 and bus_data_w[3]=1; a simultaneous overflow event wins (overflow stays 1).
REQ-014 SHALL, on a read (sel, mask=0), present data on bus_data_r one cycle later: DATA -> 0; STATUS -> {16'b0, count[7:0], 4'b0, overflow, busy, empty, full}.
REQ-015 SHALL drive bus_data_r to 0 in the cycle after any non-read or unselected cycle.
REQ-016 SHALL sample count/flags for STATUS in the read cycle (pre-update values).
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP; busy = state != IDLE.
REQ-018 IDLE: if FIFO non-empty, pop head into 8-bit shift register, go START, reload baud counter.
REQ-019 START: tx=0 for DIV cycles, then DATA with bit index 0.
REQ-020 DATA: tx=shift[0] for DIV cycles per bit, shift right, after bit 7 go STOP.
REQ-021 STOP: tx=1 for DIV cycles, then IDLE; back-to-back frames allowed (next START begins one cycle after STOP ends).
REQ-022 SHALL use a baud counter counting DIV-1 down to 0; bit boundary at 0.
REQ-023 SHALL keep the FIFO count in $clog2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
REQ-024 SHALL allow simultaneous push and pop when not full: count unchanged, data order preserved.

Reset
REQ-025 SHALL, on reset: state=IDLE, tx=1, bus_data_r=0, FIFO emptied (pointers, count 0), overflow=0, baud and bit counters 0.
REQ-026 SHALL abort a frame mid-transmission on reset; tx high in the cycle after reset asserts; FIFO contents discarded.
REQ-027 SHALL ignore bus accesses in cycles where reset is high.

Structure
REQ-028 SHALL place the FSM state enum, register offsets (DATA=0, STATUS=1) and STATUS bit positions in shared package uart_pkg.
REQ-029 SHALL implement the FIFO as sub-module sync_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/count).

Verification
REQ-030 DIV=4: write 0x55 to DATA -> tx low 4 cycles from cycle 2, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; 40-cycle frame.
REQ-031 DIV=4, DEPTH=16: 18 back-to-back DATA writes -> 17 frames in order, 18th byte dropped, STATUS bit3=1.
REQ-032 Read STATUS idle after reset -> bus_data_r=0x00000002 one cycle later; 0 the cycle before.
REQ-033 Write STATUS 0x8 after overflow -> next STATUS read bit3=0; same write with a simultaneous dropped push -> bit3 stays 1.
REQ-034 Reset asserted during DATA bit 3 -> tx=1 next cycle, STATUS reads 0x00000002, no further frame.
REQ-035 DATA write with bus_mask_w=4'b0010 or sel=0 -> no push, count unchanged, tx stays high.
